ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_if.sv | 24 ++
 rtl/ex_muldiv.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide unit bus: decoded instruction fields and operands in,
// stall/busy status and HI/LO/Result out.
interface ex_muldiv_if;
  logic [5:0]  Op_i;
  logic [5:0]  Funct_i;
  logic [31:0] R1_i;
  logic [31:0] R2_i;
  logic        Flush_i;
  logic        Stall_o;
  logic        Busy_o;
  logic [31:0] HI_o;
  logic [31:0] LO_o;
  logic [31:0] Result_o;

  modport master (
    output Op_i, Funct_i, R1_i, R2_i, Flush_i,
    input  Stall_o, Busy_o, HI_o, LO_o, Result_o
  );

  modport slave (
    input  Op_i, Funct_i, R1_i, R2_i, Flush_i,
    output Stall_o, Busy_o, HI_o, LO_o, Result_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
module ex_muldiv (
  input logic     clk,
  input logic     rst,
  ex_muldiv_if.slave bus
);
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] b_r, hi, lo;
  logic        op_div, neg_q, neg_r;

  logic        is_r, dec_mul, dec_div, dec_signed;
  logic        dec_mthi, dec_mtlo, dec_mfhi, dec_mflo, start;
  logic        sign_a, sign_b;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum, div_sh, div_diff;
  logic        div_ge;
  logic [63:0] step_acc, fin;

  always_comb begin
    is_r       = (bus.Op_i == 6'b000000);
    dec_mul    = is_r && (bus.Funct_i == F_MULT || bus.Funct_i == F_MULTU);
    dec_div    = is_r && (bus.Funct_i == F_DIV  || bus.Funct_i == F_DIVU);
    dec_signed = (bus.Funct_i == F_MULT) || (bus.Funct_i == F_DIV);
    dec_mthi   = is_r && (bus.Funct_i == F_MTHI);
    dec_mtlo   = is_r && (bus.Funct_i == F_MTLO);
    dec_mfhi   = is_r && (bus.Funct_i == F_MFHI);
    dec_mflo   = is_r && (bus.Funct_i == F_MFLO);
    sign_a     = dec_signed & bus.R1_i[31];
    sign_b     = dec_signed & bus.R2_i[31];
    a_mag      = sign_a ? -bus.R1_i : bus.R1_i;
    b_mag      = sign_b ? -bus.R2_i : bus.R2_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic        fast_mul;
  logic [63:0] fast_mag, fast_prod;
  always_comb begin
    start     = (state == IDLE) && dec_div && !bus.Flush_i;
    fast_mul  = (state == IDLE) && dec_mul && !bus.Flush_i;
    fast_mag  = {32'b0, a_mag} * {32'b0, b_mag};
    fast_prod = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
  end
`else
  always_comb begin
    start = (state == IDLE) && (dec_mul || dec_div) && !bus.Flush_i;
  end
`endif

  // acc holds {partial product} for multiply, {remainder, quotient-in-progress} for divide
  always_comb begin
    add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_r} : 33'd0);
    div_sh   = {acc[63:32], acc[31]};
    div_ge   = (div_sh >= {1'b0, b_r});
    div_diff = div_sh - {1'b0, b_r};
    if (op_div)
      step_acc = div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                        : {div_sh[31:0],   acc[30:0], 1'b0};
    else
      step_acc = {add_sum, acc[31:1]};
    if (op_div) begin
      fin[63:32] = neg_r ? -step_acc[63:32] : step_acc[63:32];
      fin[31:0]  = neg_q ? -step_acc[31:0]  : step_acc[31:0];
    end else begin
      fin = neg_q ? -step_acc : step_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (bus.Flush_i) state_nxt = IDLE;
               else if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Stall_o  = !bus.Flush_i && (start || state == BUSY);
    bus.Busy_o   = (state != IDLE);
    bus.HI_o     = hi;
    bus.LO_o     = lo;
    bus.Result_o = dec_mfhi ? hi : (dec_mflo ? lo : 32'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      b_r    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (!bus.Flush_i) begin
          if (start) begin
            acc    <= {32'b0, a_mag};
            b_r    <= b_mag;
            op_div <= dec_div;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            cnt    <= '0;
          end
`ifdef MULDIV_FAST_MUL_EN
          if (fast_mul) begin
            hi <= fast_prod[63:32];
            lo <= fast_prod[31:0];
          end
`endif
          if (dec_mthi) hi <= bus.R1_i;
          if (dec_mtlo) lo <= bus.R1_i;
        end
        BUSY: if (!bus.Flush_i) begin
          acc <= step_acc;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi <= fin[63:32];
            lo <= fin[31:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table with HI/LO scoreboard plus
// flush, reset and back-to-back sequences.
module tb_ex_muldiv;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] F_NOP   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MS = 0;
`else
  localparam int MS = 33;
`endif

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] r1;
    logic [31:0] r2;
    int          stalls;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if bus();
  ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t vecs[16];
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    bus.Op_i = OP_R; bus.Funct_i = F_NOP; bus.R1_i = '0; bus.R2_i = '0;
  endtask

  // Holds the instruction until a cycle with Stall_o low, then advances.
  task automatic issue(input logic [5:0] op, input logic [5:0] funct,
                       input logic [31:0] r1, input logic [31:0] r2,
                       output int stalls, output logic [31:0] res,
                       output logic busy0, output logic busy_end);
    bit done;
    done = 0; stalls = 0; res = '0; busy0 = 1'b0; busy_end = 1'b0;
    bus.Op_i = op; bus.Funct_i = funct; bus.R1_i = r1; bus.R2_i = r2;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) begin res = bus.Result_o; busy0 = bus.Busy_o; end
      if (!bus.Stall_o) begin busy_end = bus.Busy_o; done = 1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL issue_timeout: got stall stuck expected release within 100 cycles");
    end
    @(posedge clk); #1;
    drive_nop();
  endtask

  task automatic apply(input string tag, input vec_t v);
    int st; logic [31:0] r; logic b0, be; exp_t e;
    sb.push_back('{v.hi, v.lo});
    issue(v.op, v.funct, v.r1, v.r2, st, r, b0, be);
    check({tag, ".stalls"}, 32'(st), 32'(v.stalls));
    check({tag, ".res"}, r, v.res);
    check({tag, ".busy0"}, {31'b0, b0}, 32'd0);
    check({tag, ".busy_end"}, {31'b0, be}, {31'b0, v.stalls == 33});
    e = sb.pop_front();
    check({tag, ".hi"}, bus.HI_o, e.hi);
    check({tag, ".lo"}, bus.LO_o, e.lo);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_R,  F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MS, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0};
    vecs[1]  = '{OP_R,  F_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0};
    vecs[2]  = '{OP_R,  F_MFLO,  32'h0,         32'h0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_R,  F_MFHI,  32'h0,         32'h0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_R,  F_DIVU,  32'd100,       32'd0,         33, 32'd100,       32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{OP_R,  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0,         32'h8000_0000, 32'h0};
    vecs[6]  = '{OP_R,  F_MULT,  32'd3,         32'hFFFF_FFFC, MS, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'h0};
    vecs[7]  = '{OP_R,  F_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, MS, 32'h0,         32'h0000_001E, 32'h0};
    vecs[8]  = '{OP_R,  F_MULTU, 32'h1234_5678, 32'h10,        MS, 32'h1,         32'h2345_6780, 32'h0};
    vecs[9]  = '{OP_R,  F_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'h1,         32'hFFFF_FFFD, 32'h0};
    vecs[10] = '{OP_R,  F_MULT,  32'h8000_0000, 32'h8000_0000, MS, 32'h4000_0000, 32'h0,         32'h0};
    vecs[11] = '{OP_R,  F_MTHI,  32'hDEAD_BEEF, 32'h0,         0,  32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[12] = '{OP_R,  F_MTLO,  32'h0BAD_F00D, 32'h0,         0,  32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0};
    vecs[13] = '{6'h23, F_DIV,   32'd50,        32'd5,         0,  32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0};
    vecs[14] = '{OP_R,  F_DIVU,  32'hFFFF_FFFF, 32'h10,        33, 32'hF,         32'h0FFF_FFFF, 32'h0};
    vecs[15] = '{OP_R,  F_MFHI,  32'h0,         32'h0,         0,  32'hF,         32'h0FFF_FFFF, 32'hF};

    rst = 1'b1; bus.Flush_i = 1'b0; drive_nop();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.hi", bus.HI_o, 32'h0);
    check("reset.lo", bus.LO_o, 32'h0);
    check("reset.busy", {31'b0, bus.Busy_o}, 32'h0);
    check("reset.stall", {31'b0, bus.Stall_o}, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) apply($sformatf("v%0d", i), vecs[i]);

    // back-to-back DIVU: the first op's DONE cycle must not restart it
    apply("b2b_first",  '{OP_R, F_DIVU, 32'd10, 32'd3, 33, 32'h1, 32'h3, 32'h0});
    apply("b2b_second", '{OP_R, F_DIVU, 32'd9,  32'd3, 33, 32'h0, 32'h3, 32'h0});

    // flush at counter 10 with HI=LO=5 preloaded
    apply("pre_mthi", '{OP_R, F_MTHI, 32'd5, 32'h0, 0, 32'd5, 32'h3, 32'h0});
    apply("pre_mtlo", '{OP_R, F_MTLO, 32'd5, 32'h0, 0, 32'd5, 32'd5, 32'h0});
    bus.Op_i = OP_R; bus.Funct_i = F_DIVU; bus.R1_i = 32'd1000; bus.R2_i = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    check("flush.pre_stall", {31'b0, bus.Stall_o}, 32'h1);
    check("flush.pre_busy",  {31'b0, bus.Busy_o},  32'h1);
    bus.Flush_i = 1'b1;
    #1 check("flush.comb_stall", {31'b0, bus.Stall_o}, 32'h0);
    @(posedge clk); #1;
    bus.Flush_i = 1'b0; drive_nop();
    @(negedge clk);
    check("flush.busy",  {31'b0, bus.Busy_o},  32'h0);
    check("flush.stall", {31'b0, bus.Stall_o}, 32'h0);
    repeat (25) @(posedge clk);
    #1;
    check("flush.hi", bus.HI_o, 32'd5);
    check("flush.lo", bus.LO_o, 32'd5);

    // reset at counter 20 abandons the divide and clears HI/LO
    bus.Op_i = OP_R; bus.Funct_i = F_DIVU; bus.R1_i = 32'd77; bus.R2_i = 32'd5;
    repeat (21) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst.pre_busy", {31'b0, bus.Busy_o}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; drive_nop();
    @(negedge clk);
    check("rst.hi",    bus.HI_o, 32'h0);
    check("rst.lo",    bus.LO_o, 32'h0);
    check("rst.busy",  {31'b0, bus.Busy_o},  32'h0);
    check("rst.stall", {31'b0, bus.Stall_o}, 32'h0);
    @(posedge clk); #1;
    apply("post_rst_mult", '{OP_R, F_MULT, 32'd3, 32'hFFFF_FFFC, MS, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'h0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
